// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package adder_seq_pkg;

   // Width of one datapath slice handled per clock.
   localparam int BYTE_W = 8;

   // Sequencer phases: waiting for a command, stepping through bytes, reporting.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_8bit.sv
// Shared 8-bit ripple adder slice. The carry-out of the slice is reported
// on 'overflow' so the sequencer can chain it into the next byte.
module adder_8bit
   import adder_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              carry_in,
   output logic [BYTE_W-1:0] sum,
   output logic              overflow
);

   logic [BYTE_W:0] w_total;

   // Nine-bit sum so that the top bit carries into the next byte.
   always_comb begin
      w_total  = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, carry_in};
      sum      = w_total[BYTE_W-1:0];
      overflow = w_total[BYTE_W];
   end

endmodule

// File: rtl/adder_seq.sv
// Multi-precision add/subtract sequencer. One shared adder_8bit slice is
// walked across the operands from the least- to the most-significant byte,
// with the byte carry kept in a register between steps.
module adder_seq
   import adder_seq_pkg::*;
#(
   parameter int NUM_BYTES = 4,
   parameter int W         = BYTE_W * NUM_BYTES
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
   input  logic         sub,
   input  logic         carry_in,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         ovf
);

   // Byte pointer is at least one bit wide even for a single-byte datapath.
   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   state_t            r_state;
   state_t            w_nextState;
   logic [W-1:0]      r_opA;
   logic [W-1:0]      r_opB;
   logic [W-1:0]      r_result;
   logic              r_carry;
   logic              r_carryOut;
   logic              r_ovf;
   logic [IDX_W-1:0]  r_idx;
   logic              w_accept;
   logic              w_step;
   logic              w_last;
   logic [BYTE_W-1:0] w_aByte;
   logic [BYTE_W-1:0] w_bByte;
   logic [BYTE_W-1:0] w_sum;
   logic              w_adderCarry;

   // Phase register; an asynchronous reset abandons any operation in flight.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next phase plus the accept/step strobes that steer the datapath.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = (r_idx == LAST_IDX);
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_nextState = ADD;
            end
         end
         ADD: begin
            w_step = 1'b1;
            if (w_last) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Pick the current byte of each latched operand for the shared adder.
   always_comb begin
      w_aByte = '0;
      w_bByte = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_aByte = r_opA[i*BYTE_W +: BYTE_W];
            w_bByte = r_opB[i*BYTE_W +: BYTE_W];
         end
      end
   end

   adder_8bit u_adder (
      .a        (w_aByte),
      .b        (w_bByte),
      .carry_in (r_carry),
      .sum      (w_sum),
      .overflow (w_adderCarry)
   );

   // Operand capture on accept, then one byte of result per ADD cycle.
   // Subtraction is a + ~b + 1, so B is stored inverted and the carry seeded
   // with 1; the sign flags are only taken on the final byte.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_opA      <= '0;
         r_opB      <= '0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_carryOut <= 1'b0;
         r_ovf      <= 1'b0;
         r_idx      <= '0;
      end else if (w_accept) begin
         r_opA   <= op_a;
         r_opB   <= sub ? ~op_b : op_b;
         r_carry <= sub ? 1'b1 : carry_in;
         r_idx   <= '0;
      end else if (w_step) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
               r_result[i*BYTE_W +: BYTE_W] <= w_sum;
            end
         end
         r_carry <= w_adderCarry;
         if (w_last) begin
            r_carryOut <= w_adderCarry;
            r_ovf      <= (r_opA[W-1] == r_opB[W-1]) &&
                          (w_sum[BYTE_W-1] != r_opA[W-1]);
         end else begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   // Outputs come straight from registers or the registered phase.
   always_comb begin
      busy      = (r_state == ADD);
      done      = (r_state == DONE);
      result    = r_result;
      carry_out = r_carryOut;
      ovf       = r_ovf;
   end

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq with NUM_BYTES = 4.
module tb_adder_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk;
   logic         n_rst;
   logic         start;
   logic         sub;
   logic         carry_in;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         ovf;

   int checks = 0;
   int errors = 0;
   logic prevC = 1'b0;
   logic prevO = 1'b0;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic         cin;
      logic [W-1:0] expRes;
      logic         expC;
      logic         expO;
   } vec_t;

   vec_t vecs[7];

   adder_seq #(.NUM_BYTES(NB)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .sub       (sub),
      .carry_in  (carry_in),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .ovf       (ovf)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: bumps the check count and reports any difference.
   task automatic checkOutput(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference arithmetic done on wide integers: unsigned carry from the
   // magnitude of the sum, overflow from the exact signed result's range.
   task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic cin,
                           output logic [W-1:0] res, output logic c,
                           output logic o);
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ut;
      longint          st;
      if (s) begin
         ut = ua - ub;
         c  = (ua >= ub);
         st = sa - sb;
      end else begin
         ut = ua + ub + longint'(cin);
         c  = (ut >= 64'h1_0000_0000);
         st = sa + sb + longint'(cin);
      end
      res = ut[W-1:0];
      o   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
   endtask

   // Runs one operation starting at a negedge and checks timing, flag hold,
   // final values and result hold. Inputs are scrambled after acceptance;
   // with holdStart, start stays high during ADD/DONE to probe busy blocking.
   task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic s,
                                input logic cin, input bit holdStart,
                                input logic [W-1:0] expRes, input logic expC,
                                input logic expO);
      op_a = a; op_b = b; sub = s; carry_in = cin; start = 1'b1;
      @(negedge clk);
      start    = holdStart;
      op_a     = $urandom;
      op_b     = $urandom;
      sub      = 1'($urandom);
      carry_in = 1'($urandom);
      for (int k = 0; k < NB; k++) begin
         checkOutput({tag, " busy/done"}, {30'd0, busy, done}, 32'd2);
         checkOutput({tag, " flags hold"}, {30'd0, carry_out, ovf}, {30'd0, prevC, prevO});
         @(negedge clk);
         op_a = $urandom;
         op_b = $urandom;
      end
      checkOutput({tag, " done pulse"}, {30'd0, busy, done}, 32'd1);
      checkOutput({tag, " result"}, result, expRes);
      checkOutput({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, expC});
      checkOutput({tag, " ovf"}, {31'd0, ovf}, {31'd0, expO});
      @(negedge clk);
      checkOutput({tag, " idle after done"}, {30'd0, busy, done}, 32'd0);
      checkOutput({tag, " result held"}, result, expRes);
      start = 1'b0;
      prevC = expC;
      prevO = expO;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      logic         rc;
      logic [W-1:0] er;
      logic         ec;
      logic         eo;

      vecs[0] = '{"ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{"add cin", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
      vecs[2] = '{"add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{"sub borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[4] = '{"sub cin ign", 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[5] = '{"add neg ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[6] = '{"sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

      n_rst = 1'b0; start = 1'b0; sub = 1'b0; carry_in = 1'b0;
      op_a = '0; op_b = '0;

      // Power-on reset, then idle cycles with no start.
      repeat (2) @(negedge clk);
      checkOutput("reset outputs", {27'd0, busy, done, carry_out, ovf, |result}, 32'd0);
      n_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("idle no start", {29'd0, busy, done, |result}, 32'd0);
      end

      // Directed table, run back to back so each start lands in IDLE.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s,
                       vecs[i].cin, 1'b0, vecs[i].expRes, vecs[i].expC,
                       vecs[i].expO);
      end

      // Reset while idle clears the held result and flags.
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      checkOutput("idle reset result", result, 32'd0);
      checkOutput("idle reset flags", {28'd0, busy, done, carry_out, ovf}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      prevC = 1'b0;
      prevO = 1'b0;
      @(negedge clk);

      // Busy protection: start held high and inputs changing throughout.
      refModel(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1, er, ec, eo);
      applyStimulus("busy protect", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1,
                    1'b1, er, ec, eo);

      // Abort after two bytes have been written.
      op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; sub = 1'b0; carry_in = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      #1;
      checkOutput("midop reset result", result, 32'd0);
      checkOutput("midop reset flags", {28'd0, busy, done, carry_out, ovf}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) n_rst = 1'b1;
         checkOutput("no done after abort", {30'd0, busy, done}, 32'd0);
      end
      prevC = 1'b0;
      prevO = 1'b0;
      applyStimulus("after abort", 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0,
                    1'b0, 32'h0202_0202, 1'b0, 1'b0);

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 0) rb = ~ra;
         if (i % 4 == 1) rb = ra;
         rs = 1'($urandom);
         rc = 1'($urandom);
         refModel(ra, rb, rs, rc, er, ec, eo);
         applyStimulus("random", ra, rb, rs, rc, (i % 3 == 0), er, ec, eo);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_seq.md
# adder_seq

Multi-precision add/subtract sequencer that computes a NUM_BYTES-wide sum by time-multiplexing a single `adder_8bit` instance, one byte per clock, from least- to most-significant byte. Carry is chained between bytes in a register. The block sits between a requester issuing start/operand commands and the shared 8-bit adder datapath. It reports the result, unsigned carry and signed overflow with a one-cycle done pulse.

## Interface
- NUM_BYTES, 4, operand width in bytes (≥1); the datapath width W = 8*NUM_BYTES.
- clk  in  1  system clock, rising-edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract (a − b); latched with start.
- carry_in  in  1  initial carry for add; ignored when sub=1.
- op_a  in  W  operand A; latched with start.
- op_b  in  W  operand B; latched with start.
- busy  out  1  high while in ADD.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  W  sum/difference; held until the next accepted start.
- carry_out  out  1  carry from the MSB byte (for subtract, 1 = no borrow).
- ovf  out  1  two's-complement overflow of the full-width result.

## Operation
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at an edge latches op_a, op_b, sub and carry_in.
  - The operand-B register stores ~op_b when sub=1.
  - The carry register loads carry_in (add) or 1 (sub); byte_idx←0; go to ADD.
- ADD: each edge performs the following, then byte_idx increments.
  - Adder inputs are A[byte_idx], B'[byte_idx] and the carry register.
  - The sum byte is written into result[byte_idx].
  - The adder overflow output (carry-out) loads the carry register.
  - On the edge writing byte NUM_BYTES−1:
    - carry_out ← adder carry-out.
    - ovf ← (A[W−1] == B'[W−1]) && (sum MSB != A[W−1]).
    - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in ADD and DONE. Input changes after the accepted start have no effect on the result.
- result bytes not yet written hold their previous values during ADD. The full result is valid only when done=1 and afterwards.
- carry_out and ovf update only on the final-byte edge.
- byte_idx counter is $clog2(NUM_BYTES) bits wide, minimum 1. It never wraps past NUM_BYTES−1.
- Arithmetic is modulo 2^W; there is no saturation.

## Timing
- Reset (n_rst=0, asynchronous): state=IDLE, busy=0, done=0, result=0, carry_out=0, ovf=0, internal registers=0.
- Reset mid-operation aborts the operation immediately; there is no partial completion. After reset releases, the first start behaves normally.
- Latency: start sampled at edge t0 gives busy=1 from t0 to t(NUM_BYTES). done=1 from t(NUM_BYTES) to t(NUM_BYTES+1).
- Throughput: one operation per NUM_BYTES+2 cycles, since a start held high is re-accepted in IDLE at edge t(NUM_BYTES+2).
- All outputs are registered; no output depends combinationally on inputs.

## Structure
- Package `adder_seq_pkg`: state enum typedef (IDLE, ADD, DONE) and constant BYTE_W = 8.
- One sub-module: `adder_8bit` (ports a, b, carry_in, sum, overflow), instantiated once. Its byte-select muxes live in `adder_seq`.
- Separate next-state/output logic from the state register per the team FSM style.

## Test plan
- Reset: assert n_rst=0 mid-idle -> all outputs 0; release, no activity without start.
- Add with full carry ripple: NUM_BYTES=4, a=0xFFFFFFFF, b=0x00000001, cin=0 -> result 0x00000000, carry_out=1, ovf=0. busy high 4 cycles; done pulses at t4 for 1 cycle.
- Add with carry_in: a=0x12345678, b=0x11111111, cin=1 -> 0x2345678A, carry_out=0, ovf=0. Also a=0x7FFFFFFF, b=1 -> 0x80000000, ovf=1, carry_out=0.
- Subtract: 0x00000000 − 0x00000001 -> 0xFFFFFFFF, carry_out=0, ovf=0. 0x80000000 − 1 -> 0x7FFFFFFF, carry_out=1, ovf=1. carry_in=0 is ignored in both.
- Busy protection: a second start and new op_a/op_b/sub during ADD and DONE -> ignored; result equals the first operation; next start is accepted only in IDLE.
- Reset mid-op: drop n_rst after 2 bytes written -> outputs 0 and no done pulse. A following start of 0x01010101+0x01010101 -> 0x02020202.
